// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings and bus-level constants used by
// the target, the controller and their benches.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WR_HI,
    ST_WR_HI_ACK,
    ST_WR_LO,
    ST_WR_LO_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Position of the R/W flag within the address byte
  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives bus events
// (SCL edges, START, STOP) purely from the synchronized values.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_h;
  logic                   sda_h;
  logic                   scl_s;

  // Everything resets to the idle-bus level so reset never fabricates an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_h    <= scl_s;
      sda_h    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;

  // SCL must be high on both samples, so a simultaneous SCL fall never looks like START/STOP
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target bridging address/pointer/data-pair transactions onto an
// 8-bit-addressed, 16-bit-wide register-file port; SDA is open-drain only.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [7:0]  reg_addr,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  output logic        rd_req,
  input  logic [15:0] rd_data,
  output logic        busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic [15:0] tx_q, tx_d;
  logic        hi_sel_q, hi_sel_d;
  logic [7:0]  reg_addr_d;
  logic [15:0] wr_data_d;
  logic        wr_valid_d, rd_req_d, sda_oe_d, busy_d;
  logic [7:0]  rx_byte, cur_byte;
  logic [2:0]  bit_idx;

  assign rx_byte  = {shreg_q, sda_s};
  assign cur_byte = hi_sel_q ? tx_q[15:8] : tx_q[7:0];
  assign bit_idx  = 3'd7 - cnt_q[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      shreg_q   <= 7'd0;
      data_hi_q <= 8'h00;
      tx_q      <= 16'h0000;
      hi_sel_q  <= 1'b1;
      reg_addr  <= 8'h00;
      wr_data   <= 16'h0000;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_hi_q <= data_hi_d;
      tx_q      <= tx_d;
      hi_sel_q  <= hi_sel_d;
      reg_addr  <= reg_addr_d;
      wr_data   <= wr_data_d;
      wr_valid  <= wr_valid_d;
      rd_req    <= rd_req_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    data_hi_d  = data_hi_q;
    tx_d       = tx_q;
    hi_sel_d   = hi_sel_q;
    reg_addr_d = reg_addr;
    wr_data_d  = wr_data;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    sda_oe_d   = sda_oe;
    busy_d     = busy;

    // Read word is captured the cycle after the request pulse
    if (rd_req) tx_d = rd_data;

    if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
      hi_sel_d = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WR_HI, ST_WR_LO: begin
          if (scl_rise) begin
            shreg_d = rx_byte[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              case (state_q)
                ST_ADDR: begin
                  if (rx_byte[7:1] == ADDRESS) begin
                    state_d  = ST_ADDR_ACK;
                    rd_req_d = rx_byte[RW_BIT];
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                ST_REG: begin
                  reg_addr_d = rx_byte;
                  state_d    = ST_REG_ACK;
                end
                ST_WR_HI: begin
                  data_hi_d = rx_byte;
                  state_d   = ST_WR_HI_ACK;
                end
                default: begin
                  wr_data_d  = {data_hi_q, rx_byte};
                  wr_valid_d = 1'b1;
                  state_d    = ST_WR_LO_ACK;
                end
              endcase
            end
          end
        end

        // First fall after the byte starts the ACK, the second one ends it
        ST_ADDR_ACK, ST_REG_ACK, ST_WR_HI_ACK, ST_WR_LO_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              case (state_q)
                ST_ADDR_ACK: begin
                  if (shreg_q[RW_BIT]) begin
                    state_d  = ST_RD_BYTE;
                    cnt_d    = 4'd0;
                    sda_oe_d = ~cur_byte[7];
                  end else begin
                    state_d = ST_REG;
                  end
                end
                ST_REG_ACK:   state_d = ST_WR_HI;
                ST_WR_HI_ACK: state_d = ST_WR_LO;
                default: begin
                  reg_addr_d = reg_addr + 8'd1;
                  state_d    = ST_WR_HI;
                end
              endcase
            end
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise && cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d = ~cur_byte[bit_idx];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              state_d = ST_RD_BYTE;
              cnt_d   = 4'd0;
              if (hi_sel_q) begin
                hi_sel_d = 1'b0;
              end else begin
                hi_sel_d   = 1'b1;
                reg_addr_d = reg_addr + 8'd1;
                rd_req_d   = 1'b1;
              end
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        default: sda_oe_d = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged controller drives the bus
// while scoreboards collect wr_valid / rd_req events from the register port.
module tb_i2c_target;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        tb_sda_low = 1'b0;
  logic        sda_line;
  logic        sda_oe, wr_valid, rd_req, busy;
  logic [7:0]  reg_addr;
  logic [15:0] wr_data, rd_data;
  logic [15:0] rd_mem_word = 16'h0000;
  logic [7:0]  rd_mem_addr = 8'h00;
  logic        last_bit = 1'b1;

  int checks = 0;
  int errors = 0;
  int drive_cycles = 0;
  int wr_idx = 0;
  int rd_idx = 0;

  logic [23:0] exp_wr[$];
  logic [23:0] obs_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  obs_rd[$];

  assign sda_line = ~(sda_oe | tb_sda_low);
  assign rd_data  = (reg_addr == rd_mem_addr) ? rd_mem_word : 16'hFFFF;

  always #5 clk = ~clk;

  i2c_target #(.ADDRESS(7'h48), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (wr_valid) obs_wr.push_back({reg_addr, wr_data});
    if (rd_req) obs_rd.push_back(reg_addr);
    if (sda_oe) drive_cycles++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    wait_clk(10);
    tb_sda_low = ~b;
    wait_clk(10);
    scl = 1'b1;
    wait_clk(10);
    last_bit = sda_line;
    wait_clk(10);
    scl = 1'b0;
  endtask

  task automatic do_start();
    if (!scl) begin
      wait_clk(10);
      tb_sda_low = 1'b0;
      wait_clk(10);
      scl = 1'b1;
      wait_clk(10);
    end
    tb_sda_low = 1'b1;
    wait_clk(10);
    scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(10);
    tb_sda_low = 1'b1;
    wait_clk(10);
    scl = 1'b1;
    wait_clk(10);
    tb_sda_low = 1'b0;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(1'b1);
  endtask

  task automatic read_byte(input logic ack_val, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1);
      d[i] = last_bit;
    end
    send_bit(ack_val);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(5);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b, expected 0", sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_valid: got %b, expected 0", wr_valid); end
    checks++; if (rd_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_req: got %b, expected 0", rd_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg_addr: got %h, expected 00", reg_addr); end
    checks++; if (wr_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wr_data: got %h, expected 0000", wr_data); end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write();
    logic [7:0]  seq [4];
    logic [23:0] e;
    seq = '{8'h90, 8'h10, 8'hAB, 8'hCD};
    exp_wr.push_back({8'h10, 16'hABCD});
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_start: got %b, expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      write_byte(seq[i]);
      checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL write_ack%0d: got %b, expected %b", i, last_bit, I2C_ACK); end
    end
    do_stop();
    wait_clk(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_stop: got %b, expected 0", busy); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checks++;
      if (wr_idx >= obs_wr.size()) begin errors++; $display("[TB] FAIL write_event: got none, expected %h", e); end
      else begin
        if (obs_wr[wr_idx] !== e) begin errors++; $display("[TB] FAIL write_event: got %h, expected %h", obs_wr[wr_idx], e); end
        wr_idx++;
      end
    end
    checks++; if (obs_wr.size() != wr_idx) begin errors++; $display("[TB] FAIL write_extra: got %0d events, expected %0d", obs_wr.size(), wr_idx); wr_idx = obs_wr.size(); end
  endtask

  task automatic test_read();
    logic [7:0] b;
    logic [7:0] e;
    int wr_before;
    rd_mem_addr = 8'h22;
    rd_mem_word = 16'h1234;
    wr_before = obs_wr.size();
    do_start();
    write_byte(8'h90);
    checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL read_ptr_ack_addr: got %b, expected 0", last_bit); end
    write_byte(8'h22);
    checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL read_ptr_ack_reg: got %b, expected 0", last_bit); end
    do_stop();
    wait_clk(5);
    checks++; if (reg_addr !== 8'h22) begin errors++; $display("[TB] FAIL read_ptr_reg_addr: got %h, expected 22", reg_addr); end
    checks++; if (obs_wr.size() != wr_before) begin errors++; $display("[TB] FAIL read_ptr_no_write: got %0d events, expected %0d", obs_wr.size(), wr_before); end
    exp_rd.push_back(8'h22);
    exp_rd.push_back(8'h23);
    do_start();
    write_byte(8'h91);
    checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL read_ack_addr: got %b, expected 0", last_bit); end
    read_byte(I2C_ACK, b);
    checks++; if (b !== 8'h12) begin errors++; $display("[TB] FAIL read_byte_hi: got %h, expected 12", b); end
    read_byte(I2C_ACK, b);
    checks++; if (b !== 8'h34) begin errors++; $display("[TB] FAIL read_byte_lo: got %h, expected 34", b); end
    do_stop();
    wait_clk(5);
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      checks++;
      if (rd_idx >= obs_rd.size()) begin errors++; $display("[TB] FAIL read_req: got none, expected addr %h", e); end
      else begin
        if (obs_rd[rd_idx] !== e) begin errors++; $display("[TB] FAIL read_req: got addr %h, expected %h", obs_rd[rd_idx], e); end
        rd_idx++;
      end
    end
    checks++; if (obs_rd.size() != rd_idx) begin errors++; $display("[TB] FAIL read_req_extra: got %0d, expected %0d", obs_rd.size(), rd_idx); rd_idx = obs_rd.size(); end
    checks++; if (reg_addr !== 8'h23) begin errors++; $display("[TB] FAIL read_reg_addr_inc: got %h, expected 23", reg_addr); end
  endtask

  task automatic test_nack_restart();
    logic [7:0] b;
    logic [7:0] e;
    int drv_before;
    rd_mem_addr = 8'h30;
    rd_mem_word = 16'hA55A;
    do_start();
    write_byte(8'h90);
    write_byte(8'h30);
    do_stop();
    exp_rd.push_back(8'h30);
    do_start();
    write_byte(8'h91);
    checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL nack_ack_addr: got %b, expected 0", last_bit); end
    read_byte(I2C_NACK, b);
    checks++; if (b !== 8'hA5) begin errors++; $display("[TB] FAIL nack_byte_hi: got %h, expected a5", b); end
    wait_clk(6);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL nack_released: got %b, expected 0", sda_oe); end
    drv_before = drive_cycles;
    send_bit(1'b1);
    checks++; if (drive_cycles != drv_before) begin errors++; $display("[TB] FAIL nack_low_slot_driven: got %0d cycles, expected 0", drive_cycles - drv_before); end
    do_start();
    write_byte(8'h90);
    checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL restart_ack_addr: got %b, expected 0", last_bit); end
    write_byte(8'h40);
    checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL restart_ack_reg: got %b, expected 0", last_bit); end
    do_stop();
    wait_clk(5);
    checks++; if (reg_addr !== 8'h40) begin errors++; $display("[TB] FAIL restart_reg_addr: got %h, expected 40", reg_addr); end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      checks++;
      if (rd_idx >= obs_rd.size()) begin errors++; $display("[TB] FAIL nack_req: got none, expected addr %h", e); end
      else begin
        if (obs_rd[rd_idx] !== e) begin errors++; $display("[TB] FAIL nack_req: got addr %h, expected %h", obs_rd[rd_idx], e); end
        rd_idx++;
      end
    end
    checks++; if (obs_rd.size() != rd_idx) begin errors++; $display("[TB] FAIL nack_req_extra: got %0d, expected %0d", obs_rd.size(), rd_idx); rd_idx = obs_rd.size(); end
  endtask

  task automatic test_stream_wrap();
    logic [7:0]  seq [6];
    logic [23:0] e;
    seq = '{8'h90, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_wr.push_back({8'hFF, 16'h0102});
    exp_wr.push_back({8'h00, 16'h0304});
    do_start();
    for (int i = 0; i < 6; i++) begin
      write_byte(seq[i]);
      checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL stream_ack%0d: got %b, expected 0", i, last_bit); end
    end
    do_stop();
    wait_clk(5);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checks++;
      if (wr_idx >= obs_wr.size()) begin errors++; $display("[TB] FAIL stream_event: got none, expected %h", e); end
      else begin
        if (obs_wr[wr_idx] !== e) begin errors++; $display("[TB] FAIL stream_event: got %h, expected %h", obs_wr[wr_idx], e); end
        wr_idx++;
      end
    end
    checks++; if (obs_wr.size() != wr_idx) begin errors++; $display("[TB] FAIL stream_extra: got %0d, expected %0d", obs_wr.size(), wr_idx); wr_idx = obs_wr.size(); end
    checks++; if (reg_addr !== 8'h01) begin errors++; $display("[TB] FAIL stream_reg_addr: got %h, expected 01", reg_addr); end
  endtask

  task automatic test_addr_mismatch();
    logic [7:0] seq [3];
    int drv_before, wr_before, rd_before;
    seq = '{8'h92, 8'h10, 8'h55};
    drv_before = drive_cycles;
    wr_before  = obs_wr.size();
    rd_before  = obs_rd.size();
    do_start();
    for (int i = 0; i < 3; i++) begin
      write_byte(seq[i]);
      checks++; if (last_bit !== I2C_NACK) begin errors++; $display("[TB] FAIL mismatch_ack%0d: got %b, expected 1", i, last_bit); end
    end
    do_stop();
    wait_clk(5);
    checks++; if (drive_cycles != drv_before) begin errors++; $display("[TB] FAIL mismatch_sda_driven: got %0d cycles, expected 0", drive_cycles - drv_before); end
    checks++; if (obs_wr.size() != wr_before || obs_rd.size() != rd_before) begin errors++; $display("[TB] FAIL mismatch_events: got wr %0d rd %0d, expected wr %0d rd %0d", obs_wr.size(), obs_rd.size(), wr_before, rd_before); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  seq [4];
    logic [23:0] e;
    int wr_before;
    wr_before = obs_wr.size();
    do_start();
    write_byte(8'h90);
    write_byte(8'h50);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    wait_clk(1);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL midreset_sda_oe: got %b, expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); end
    wait_clk(3);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++; if (last_bit !== I2C_NACK) begin errors++; $display("[TB] FAIL midreset_ack: got %b, expected 1", last_bit); end
    write_byte(8'hCD);
    do_stop();
    wait_clk(5);
    checks++; if (obs_wr.size() != wr_before) begin errors++; $display("[TB] FAIL midreset_write: got %0d events, expected %0d", obs_wr.size(), wr_before); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("[TB] FAIL midreset_reg_addr: got %h, expected 00", reg_addr); end
    seq = '{8'h90, 8'h60, 8'hBE, 8'hEF};
    exp_wr.push_back({8'h60, 16'hBEEF});
    do_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(seq[i]);
      checks++; if (last_bit !== I2C_ACK) begin errors++; $display("[TB] FAIL fresh_ack%0d: got %b, expected 0", i, last_bit); end
    end
    do_stop();
    wait_clk(5);
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checks++;
      if (wr_idx >= obs_wr.size()) begin errors++; $display("[TB] FAIL fresh_event: got none, expected %h", e); end
      else begin
        if (obs_wr[wr_idx] !== e) begin errors++; $display("[TB] FAIL fresh_event: got %h, expected %h", obs_wr[wr_idx], e); end
        wr_idx++;
      end
    end
    checks++; if (obs_wr.size() != wr_idx) begin errors++; $display("[TB] FAIL fresh_extra: got %0d, expected %0d", obs_wr.size(), wr_idx); wr_idx = obs_wr.size(); end
  endtask

  initial begin
    $display("[TB] starting i2c_target bench");
    test_reset();
    test_write();
    test_read();
    test_nack_restart();
    test_stream_wrap();
    test_addr_mismatch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
